// File: rtl/f8_fetch_queue.sv
// rtl/f8_fetch_queue.sv - f8 instruction prefetch byte queue driving split even/odd program banks
module f8_fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [15:0] RESET_PC = 16'h4000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [14:0] mem_read_addr_even,
    input  logic [7:0]  mem_read_data_even,
    output logic [14:0] mem_read_addr_odd,
    input  logic [7:0]  mem_read_data_odd,
    output logic        mem_read_en,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic [1:0]  consume_len,
    output logic [23:0] inst,
    output logic [15:0] inst_pc,
    output logic [1:0]  inst_avail,
    output logic        underflow_err
);
    localparam int CW = $clog2(DEPTH + 5);

    logic [7:0]    q     [DEPTH];
    logic [7:0]    q_nxt [DEPTH];
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] base;
    logic [15:0]   head_pc;
    logic [15:0]   fetch_pc;
    logic [15:0]   req_a;
    logic          inflight;
    logic          req_odd;
    logic [1:0]    avail;
    logic [1:0]    cons;
    logic          issue;
    logic          arrive;
    logic [7:0]    byte_lo;
    logic [7:0]    byte_hi;
    int            fill;

    assign avail   = (count >= CW'(3)) ? 2'd3 : count[1:0];
    assign cons    = (consume_len > avail) ? avail : consume_len;
    assign req_a   = redirect ? redirect_pc : fetch_pc;

    // The in-flight pair is reserved up front so the queue can never overflow.
    assign fill    = int'(count) + (inflight ? 2 : 0) + 2;
    assign issue   = redirect || (fill <= DEPTH);
    assign arrive  = inflight && !redirect;

    assign mem_read_en        = !reset && issue;
    assign mem_read_addr_odd  = req_a[15:1];
    assign mem_read_addr_even = req_a[15:1] + {14'd0, req_a[0]};

    // An odd start address returns its first byte from the odd bank.
    assign byte_lo = req_odd ? mem_read_data_odd  : mem_read_data_even;
    assign byte_hi = req_odd ? mem_read_data_even : mem_read_data_odd;

    always_comb begin
        base      = count - CW'(cons);
        count_nxt = base + (arrive ? CW'(2) : CW'(0));
        for (int i = 0; i < DEPTH; i++) begin
            q_nxt[i] = 8'd0;
            for (int j = 0; j < DEPTH; j++) begin
                if (CW'(j) == CW'(i) + CW'(cons)) begin
                    q_nxt[i] = q[j];
                end
            end
            if (arrive && (CW'(i) == base)) begin
                q_nxt[i] = byte_lo;
            end
            if (arrive && (CW'(i) == base + CW'(1))) begin
                q_nxt[i] = byte_hi;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            q[i] <= q_nxt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count         <= '0;
            head_pc       <= RESET_PC;
            fetch_pc      <= RESET_PC;
            inflight      <= 1'b0;
            req_odd       <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= req_a + 16'd2;
                req_odd  <= req_a[0];
            end
            if (redirect) begin
                count   <= '0;
                head_pc <= redirect_pc;
            end else begin
                count   <= count_nxt;
                head_pc <= head_pc + {14'd0, cons};
                if (consume_len > avail) begin
                    underflow_err <= 1'b1;
                end
            end
        end
    end

    assign inst       = {(avail > 2'd2) ? q[2] : 8'd0,
                         (avail > 2'd1) ? q[1] : 8'd0,
                         (avail > 2'd0) ? q[0] : 8'd0};
    assign inst_pc    = head_pc;
    assign inst_avail = avail;
endmodule

// File: tb/tb_f8_fetch_queue.sv
// tb/tb_f8_fetch_queue.sv - scoreboard bench for f8_fetch_queue against a byte-stream model
module tb_f8_fetch_queue;
    localparam int          DEPTH    = 8;
    localparam logic [15:0] RESET_PC = 16'h4000;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] mem_read_addr_even;
    logic [7:0]  mem_read_data_even;
    logic [14:0] mem_read_addr_odd;
    logic [7:0]  mem_read_data_odd;
    logic        mem_read_en;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [1:0]  consume_len;
    logic [23:0] inst;
    logic [15:0] inst_pc;
    logic [1:0]  inst_avail;
    logic        underflow_err;

    f8_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_read_addr_even (mem_read_addr_even),
        .mem_read_data_even (mem_read_data_even),
        .mem_read_addr_odd  (mem_read_addr_odd),
        .mem_read_data_odd  (mem_read_data_odd),
        .mem_read_en        (mem_read_en),
        .redirect           (redirect),
        .redirect_pc        (redirect_pc),
        .consume_len        (consume_len),
        .inst               (inst),
        .inst_pc            (inst_pc),
        .inst_avail         (inst_avail),
        .underflow_err      (underflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memf(logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    // Program memory: one-cycle read latency per bank.
    always @(posedge clk) begin
        mem_read_data_even <= memf({mem_read_addr_even, 1'b0});
        mem_read_data_odd  <= memf({mem_read_addr_odd, 1'b1});
    end

    typedef struct {
        logic [23:0] inst;
        logic [15:0] pc;
        logic [1:0]  avail;
        logic        err;
        logic        en;
        logic [14:0] ea;
        logic [14:0] oa;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  bq[$];
    logic [15:0] m_head;
    logic [15:0] m_fetch;
    logic [15:0] m_req;
    bit          m_infl;
    bit          m_err;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("inst",       32'(inst),               32'(e.inst));
            chk("inst_pc",    32'(inst_pc),            32'(e.pc));
            chk("inst_avail", 32'(inst_avail),         32'(e.avail));
            chk("underflow",  32'(underflow_err),      32'(e.err));
            chk("read_en",    32'(mem_read_en),        32'(e.en));
            chk("addr_even",  32'(mem_read_addr_even), 32'(e.ea));
            chk("addr_odd",   32'(mem_read_addr_odd),  32'(e.oa));
        end
    end

    task automatic model_reset();
        bq.delete();
        m_head  = RESET_PC;
        m_fetch = RESET_PC;
        m_infl  = 1'b0;
        m_err   = 1'b0;
    endtask

    // Drive one cycle, queue the expected outputs, then advance the model past the edge.
    task automatic step(bit rst, bit rd, logic [15:0] rpc, logic [1:0] cons);
        exp_t        e;
        logic [15:0] a;
        logic [15:0] eb;
        logic [15:0] ob;
        int          avail;
        int          n;
        bit          iss;
        bit          arrived;
        reset       = rst;
        redirect    = rd;
        redirect_pc = rpc;
        consume_len = cons;
        a     = rd ? rpc : m_fetch;
        eb    = a[0] ? a + 16'd1 : a;
        ob    = a[0] ? a : a + 16'd1;
        avail = (bq.size() < 3) ? bq.size() : 3;
        iss   = !rst && (rd || (bq.size() + (m_infl ? 2 : 0) + 2 <= DEPTH));
        e.inst = 24'd0;
        for (int k = 0; k < avail; k++) e.inst[8*k +: 8] = bq[k];
        e.pc    = m_head;
        e.avail = 2'(avail);
        e.err   = m_err;
        e.en    = iss;
        e.ea    = eb[15:1];
        e.oa    = ob[15:1];
        exp_q.push_back(e);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            arrived = m_infl && !rd;
            if (rd) begin
                bq.delete();
                m_head = rpc;
            end else begin
                n = (int'(cons) > avail) ? avail : int'(cons);
                if (int'(cons) > avail) m_err = 1'b1;
                repeat (n) void'(bq.pop_front());
                m_head = m_head + 16'(n);
            end
            if (arrived) begin
                bq.push_back(memf(m_req));
                bq.push_back(memf(m_req + 16'd1));
            end
            if (iss) begin
                m_fetch = a + 16'd2;
                m_req   = a;
            end
            m_infl = iss;
        end
        #1;
    endtask

    initial begin
        bit          r;
        bit          d;
        logic [15:0] p;
        logic [1:0]  c;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 16'h0;
        consume_len = 2'd0;
        @(posedge clk);
        model_reset();
        #1;
        repeat (2) step(1, 0, 16'h0, 2'd0);
        repeat (12) step(0, 0, 16'h0, 2'd0);
        repeat (4) step(0, 0, 16'h0, 2'd3);
        repeat (6) step(0, 0, 16'h0, 2'd0);
        step(0, 0, 16'h0, 2'd3);
        step(0, 1, 16'h4001, 2'd0);
        repeat (6) step(0, 0, 16'h0, 2'd1);
        step(0, 1, 16'h1234, 2'd0);
        step(0, 1, 16'h2001, 2'd1);
        step(0, 1, 16'h3000, 2'd2);
        repeat (5) step(0, 0, 16'h0, 2'd0);
        step(0, 1, 16'hFFFE, 2'd0);
        repeat (8) step(0, 0, 16'h0, 2'd0);
        step(0, 1, 16'h0100, 2'd0);
        step(1, 0, 16'h0, 2'd0);
        repeat (3) step(0, 0, 16'h0, 2'd0);
        step(1, 1, 16'h8000, 2'd2);
        repeat (4) step(0, 0, 16'h0, 2'd2);
        for (int n = 0; n < 1500; n++) begin
            r = ($urandom_range(0, 199) == 0);
            d = ($urandom_range(0, 15) == 0);
            p = 16'($urandom);
            if ($urandom_range(0, 3) == 0) p = 16'hFFFC + 16'($urandom_range(0, 3));
            c = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            step(r, d, p, c);
        end
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
